// File: rtl/buzzer_tone_driver.sv
// Per-zone square-wave piezo driver gated into fixed on/off beep bursts.
// Optional BUZZER_BEEP_COUNT_EN builds a saturating burst counter; otherwise beep_count is tied to 0.
module buzzer_tone_driver #(
  parameter int DIV1     = 4,
  parameter int DIV2     = 6,
  parameter int DIV3     = 8,
  parameter int BEEP_ON  = 32,
  parameter int BEEP_OFF = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] alarm_in,
  output logic       tone_out,
  output logic       active,
  output logic [1:0] zone,
  output logic [7:0] beep_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic [15:0] ON_LAST  = 16'(BEEP_ON - 1);
  localparam logic [15:0] OFF_LAST = 16'(BEEP_OFF - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] tone_cnt_q, tone_cnt_d;
  logic        tone_q, tone_d;
  logic        active_q, active_d;
  logic [1:0]  zone_q, zone_d;
  logic [1:0]  pri_zone;
  logic [15:0] div_last;

  always_comb begin
    pri_zone = 2'd0;
    if (alarm_in[0])      pri_zone = 2'd1;
    else if (alarm_in[1]) pri_zone = 2'd2;
    else if (alarm_in[2]) pri_zone = 2'd3;
  end

  always_comb begin
    case (zone_q)
      2'd1:    div_last = 16'(DIV1 - 1);
      2'd2:    div_last = 16'(DIV2 - 1);
      default: div_last = 16'(DIV3 - 1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    zone_d     = zone_q;
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (alarm_in != 3'b000) begin
          state_d    = S_ON;
          zone_d     = pri_zone;
          phase_d    = 16'd0;
          tone_cnt_d = 16'd0;
        end
      end
      S_ON: begin
        if (tone_cnt_q == div_last) begin
          tone_d     = ~tone_q;
          tone_cnt_d = 16'd0;
        end else begin
          tone_cnt_d = tone_cnt_q + 16'd1;
        end
        // An odd toggle count would leave the pin high; the gap always starts low.
        if (phase_q == ON_LAST) begin
          state_d = S_OFF;
          phase_d = 16'd0;
          tone_d  = 1'b0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_OFF: begin
        tone_d = 1'b0;
        if (phase_q == OFF_LAST) begin
          phase_d = 16'd0;
          if (alarm_in != 3'b000) begin
            state_d    = S_ON;
            zone_d     = pri_zone;
            tone_cnt_d = 16'd0;
          end else begin
            state_d = S_IDLE;
            zone_d  = 2'd0;
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        zone_d  = 2'd0;
        tone_d  = 1'b0;
        phase_d = 16'd0;
      end
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 16'd0;
      tone_cnt_q <= 16'd0;
      tone_q     <= 1'b0;
      active_q   <= 1'b0;
      zone_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      active_q   <= active_d;
      zone_q     <= zone_d;
    end
  end

  assign tone_out = tone_q;
  assign active   = active_q;
  assign zone     = zone_q;

`ifdef BUZZER_BEEP_COUNT_EN
  logic       burst_start;
  logic [7:0] beep_count_q, beep_count_d;

  assign burst_start = (state_q != S_ON) && (state_d == S_ON);

  always_comb begin
    beep_count_d = beep_count_q;
    if (burst_start && (beep_count_q != 8'hFF)) beep_count_d = beep_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) beep_count_q <= 8'd0;
    else     beep_count_q <= beep_count_d;
  end

  assign beep_count = beep_count_q;
`else
  assign beep_count = 8'd0;
`endif

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Directed bench for buzzer_tone_driver at default parameters; follows BUZZER_BEEP_COUNT_EN for beep_count expectations.
module tb_buzzer_tone_driver;

`ifdef BUZZER_BEEP_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] alarm_in = 3'b000;
  logic       tone_out;
  logic       active;
  logic [1:0] zone;
  logic [7:0] beep_count;

  int n_err = 0;
  int n_chk = 0;
  int tr;

  buzzer_tone_driver dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_in   (alarm_in),
    .tone_out   (tone_out),
    .active     (active),
    .zone       (zone),
    .beep_count (beep_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    alarm_in = 3'b000;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return (CNT_EN != 0) ? 32'(n) : 32'd0;
  endfunction

  // Entered just after the burst-start edge (sample 0); returns at sample 47.
  task automatic burst_check(input string tag, input logic [1:0] ez, input int ediv,
                             input int sw_at, input logic [2:0] sw_val, output int trans);
    int   bad;
    logic prev;
    logic exp_t;
    bad   = 0;
    trans = 0;
    prev  = tone_out;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) step();
      if (i == sw_at) alarm_in = sw_val;
      exp_t = (i < 32) ? (((i / ediv) % 2) == 1) : 1'b0;
      if (tone_out !== exp_t || active !== 1'b1 || zone !== ez) bad++;
      if (i > 0 && i <= 32 && tone_out !== prev) trans++;
      prev = tone_out;
    end
    chk({tag, "_shape"}, 32'(bad), 32'd0);
  endtask

  initial begin
    // Reset held with an alarm present
    rst      = 1'b1;
    alarm_in = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", {tone_out, active, zone, beep_count}, 32'd0);
    end
    rst      = 1'b0;
    alarm_in = 3'b000;
    step();
    chk("rst_release", {tone_out, active, zone, beep_count}, 32'd0);

    // Single-cycle pulse, zone 1
    alarm_in = 3'b001;
    step();
    alarm_in = 3'b000;
    chk("pulse_cnt_start", beep_count, exp_cnt(1));
    burst_check("pulse", 2'd1, 4, -1, 3'b000, tr);
    chk("pulse_toggles", 32'(tr), 32'd8);
    step();
    chk("pulse_idle", {tone_out, active, zone}, 32'd0);
    chk("pulse_cnt_end", beep_count, exp_cnt(1));

    // Held alarm, zone 2: back-to-back bursts every 48 cycles
    do_reset();
    alarm_in = 3'b010;
    step();
    for (int b = 1; b <= 5; b++) begin
      chk("held_cnt", beep_count, exp_cnt(b));
      burst_check("held", 2'd2, 6, -1, 3'b010, tr);
      step();
    end
    chk("held_sixth", {active, zone}, {1'b1, 2'd2});

    // Zone change mid-burst takes effect only on the next burst
    do_reset();
    alarm_in = 3'b001;
    step();
    burst_check("zc_first", 2'd1, 4, 10, 3'b100, tr);
    step();
    burst_check("zc_second", 2'd3, 8, 0, 3'b000, tr);
    step();
    chk("zc_idle", {active, zone}, 32'd0);
    chk("zc_cnt", beep_count, exp_cnt(2));

    // Priority: bit1 beats bit2
    do_reset();
    alarm_in = 3'b110;
    step();
    alarm_in = 3'b000;
    burst_check("prio", 2'd2, 6, -1, 3'b000, tr);

    // Reset in the middle of a burst, alarm still asserted
    do_reset();
    alarm_in = 3'b001;
    step();
    repeat (15) step();
    chk("midrst_pre_active", active, 32'd1);
    rst = 1'b1;
    step();
    chk("midrst", {tone_out, active, zone, beep_count}, 32'd0);
    rst      = 1'b0;
    alarm_in = 3'b000;
    step();
    chk("midrst_after", {tone_out, active, zone, beep_count}, 32'd0);

    // Saturation over 300 bursts
    do_reset();
    alarm_in = 3'b100;
    step();
    for (int b = 1; b <= 300; b++) begin
      if (b == 254) chk("sat_254", beep_count, exp_cnt(254));
      if (b == 255) chk("sat_255", beep_count, exp_cnt(255));
      if (b == 300) chk("sat_300", beep_count, exp_cnt(255));
      repeat (48) step();
    end
    chk("sat_zone", zone, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_driver.md
# buzzer_tone_driver

- Downstream stage of the zone alarm detector: turns its three per-zone buzzer levels into an audible square-wave drive for a single piezo pin.
- Each zone gets a distinct pitch.
- Output is gated into fixed on/off beep bursts that repeat while any alarm level is held.
- Also reports the active zone and, optionally, a burst counter.

## Interface
- `DIV1`, default 4: tone half-period in cycles for zone 1; range 1..65535.
- `DIV2`, default 6: tone half-period for zone 2; range 1..65535.
- `DIV3`, default 8: tone half-period for zone 3; range 1..65535.
- `BEEP_ON`, default 32: burst length in cycles; range 1..65535.
- `BEEP_OFF`, default 16: gap length in cycles; range 1..65535.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `alarm_in` input 3: buzzer levels from the detector; bit0 = zone 1, bit1 = zone 2, bit2 = zone 3.
- `tone_out` output 1: square-wave piezo drive.
- `active` output 1: high during a burst or gap.
- `zone` output 2: latched zone of the current burst; 0 when idle.
- `beep_count` output 8: saturating count of bursts started.

## Operation
- FSM states: IDLE, ON, OFF.
- **IDLE**
  - `tone_out`=0, `active`=0, `zone`=0.
  - On any edge with `alarm_in`≠0, go to ON.
  - Latch `zone` using priority bit0 > bit1 > bit2, e.g. 3'b011 gives zone 1.
- **ON**
  - Phase counter runs 0..`BEEP_ON`-1.
  - Tone counter runs 0..DIVz-1, where z is the latched zone.
  - When the tone counter reaches DIVz-1: toggle `tone_out` and wrap the tone counter to 0.
  - When the phase counter reaches `BEEP_ON`-1: go to OFF.
  - `alarm_in` is ignored in ON: a burst always runs full length, and its zone/pitch never changes mid-burst.
- **OFF**
  - `tone_out` forced 0; phase counter runs 0..`BEEP_OFF`-1.
  - On the last cycle, sample `alarm_in`.
  - If nonzero: go to ON, re-latch `zone` by priority, reset the tone counter.
  - If zero: go to IDLE and clear `zone`.
- `active` = 1 in ON and OFF.
- `beep_count` increments on every transition into ON and holds at 255.
- Counters are 16-bit unsigned, with no wrap beyond the stated terminal values.
- Invalid `alarm_in` patterns need no special handling; the priority rule covers all of them.

## Timing
- All outputs are registered.
- Latency: `alarm_in` seen nonzero at edge N in IDLE → `active`=1, `zone` valid, and `beep_count` updated after edge N.
- `tone_out` is 0 at burst start; its first rising edge occurs DIVz cycles after entry.
- Each burst produces exactly floor(`BEEP_ON`/DIVz) toggles. If that count is odd, `tone_out` is forced back to 0 on entry to OFF.
- Burst-to-burst period with alarm held: `BEEP_ON`+`BEEP_OFF` cycles, with no idle cycle between.
- A one-cycle `alarm_in` pulse in IDLE still yields one complete burst plus gap: `active` high for exactly `BEEP_ON`+`BEEP_OFF` cycles.
- Reset:
  - `rst` high at any edge, including mid-burst: next state is IDLE.
  - All outputs and counters are 0 after that edge.
  - `rst` dominates `alarm_in`.
  - Reset values: `tone_out`=0, `active`=0, `zone`=0, `beep_count`=0.

## Configuration
- `BUZZER_BEEP_COUNT_EN`
  - Defined: the `beep_count` register and saturating incrementer are built as above.
  - Undefined: the counter logic is omitted and `beep_count` is tied to 8'd0.
  - Either way, the port list and all other behaviour are unchanged.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `alarm_in`=3'b001 → `tone_out`, `active`, `zone`, and `beep_count` all 0 throughout and on the first cycle after release.
- Single pulse:
  - Stimulus: `alarm_in`=3'b001 for 1 cycle, defaults.
  - `zone`=1 and `active` high for 48 cycles.
  - `tone_out` period 8 cycles, 8 toggles in ON, then 0.
  - Returns to IDLE; `beep_count`=1 with the macro defined, 0 without.
- Held alarm: `alarm_in`=3'b010 for 200 cycles → bursts start every 48 cycles with tone period 12; `beep_count`=5 after the fifth burst starts.
- Zone change: `alarm_in` 3'b001, switched to 3'b100 at cycle 10 of ON → first burst stays zone 1/DIV1; the next burst has `zone`=3 with tone period 16.
- Priority: `alarm_in`=3'b110 → `zone`=2, tone period 12.
- Mid-burst reset, and saturation (macro defined):
  - `rst` asserted at cycle 15 of ON → all outputs 0 the next cycle.
  - Holding any alarm for 300 bursts → `beep_count` stops at 255.
